// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: PC register, IF/ID register and the ID/EX and EX/MEM control
// registers, driven by the hazard unit's hold/bubble/flush outputs.
// Also contains a stall watchdog that flags a pipeline held for too long.
//
// Optional feature: define PERF_COUNTERS_EN to add the stall_cycles and
// flush_events performance counters.
//
// state    | meaning
// RUN      | pipeline advancing normally
// STALL    | pc_hold asserted, no redirect
// REDIRECT | branch or jump redirecting the PC
module fetch_pipe_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CTRL_W      = 16,
  parameter int          STALL_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic              pc_hold,
  input  logic              ifid_hold,
  input  logic              ctrl_bubble,
  input  logic              flush_ifid,
  input  logic              flush_idex,
  input  logic              flush_exmem,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump_taken,
  input  logic [31:0]       jump_target,
  input  logic [CTRL_W-1:0] ctrl_id,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              idex_valid,
  output logic [CTRL_W-1:0] exmem_ctrl,
  output logic              exmem_valid,
  output logic              stall_timeout
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);

  localparam int            CW    = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] hold_cnt, hold_cnt_next;
  logic          redirect;
  logic [31:0]   pc_plus4;

  assign redirect = branch_taken | jump_taken;
  assign pc_plus4 = pc + 32'd4;

  // Next state and watchdog count; the counter is always 0 outside STALL,
  // so entering STALL starts the count at 1.
  always_comb begin
    state_next    = RUN;
    hold_cnt_next = '0;
    if (redirect) begin
      state_next = REDIRECT;
    end else if (pc_hold) begin
      state_next = STALL;
    end
    if (state_next == STALL) begin
      if (state != STALL) begin
        hold_cnt_next = CW'(1);
      end else if (hold_cnt != LIMIT) begin
        hold_cnt_next = hold_cnt + CW'(1);
      end else begin
        hold_cnt_next = hold_cnt;
      end
    end
  end

  // State, watchdog counter and registered timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      hold_cnt      <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_cnt_next;
      stall_timeout <= (hold_cnt_next == LIMIT);
    end
  end

  // PC register: redirects override the hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (jump_taken) begin
      pc <= jump_target;
    end else if (!pc_hold) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: flush or redirect beats hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (flush_ifid || redirect) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (!ifid_hold) begin
      ifid_instr <= instr_in;
      ifid_pc4   <= pc_plus4;
    end
  end

  // ID/EX and EX/MEM control registers; ID/EX never holds, stalls become bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ctrl   <= '0;
      idex_valid  <= 1'b0;
      exmem_ctrl  <= '0;
      exmem_valid <= 1'b0;
    end else begin
      if (ctrl_bubble || flush_idex) begin
        idex_ctrl  <= '0;
        idex_valid <= 1'b0;
      end else begin
        idex_ctrl  <= ctrl_id;
        idex_valid <= (ifid_instr != 32'd0);
      end
      if (flush_exmem) begin
        exmem_ctrl  <= '0;
        exmem_valid <= 1'b0;
      end else begin
        exmem_ctrl  <= idex_ctrl;
        exmem_valid <= idex_valid;
      end
    end
  end

`ifdef PERF_COUNTERS_EN
  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (state == STALL) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_ifid || flush_idex || flush_exmem || redirect) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// tb_fetch_pipe_ctrl: directed bench with a reference model of the fetch
// pipeline compared every cycle, plus hand-computed literal checks.
module tb_fetch_pipe_ctrl;

  localparam int          CTRL_W      = 16;
  localparam int          STALL_LIMIT = 15;
  localparam logic [31:0] K           = 32'hA5A5_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       instr_in;
  logic              pc_hold = 0, ifid_hold = 0, ctrl_bubble = 0;
  logic              flush_ifid = 0, flush_idex = 0, flush_exmem = 0;
  logic              branch_taken = 0, jump_taken = 0;
  logic [31:0]       branch_target = 0, jump_target = 0;
  logic [CTRL_W-1:0] ctrl_id = 0;
  logic              force_zero = 0;

  logic [31:0]       pc, ifid_instr, ifid_pc4;
  logic [CTRL_W-1:0] idex_ctrl, exmem_ctrl;
  logic              idex_valid, exmem_valid, stall_timeout;

  int errors = 0;
  int checks = 0;

  fetch_pipe_ctrl #(
    .RESET_PC(32'h0), .CTRL_W(CTRL_W), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ctrl_bubble(ctrl_bubble),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_taken(jump_taken), .jump_target(jump_target), .ctrl_id(ctrl_id),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .idex_ctrl(idex_ctrl), .idex_valid(idex_valid),
    .exmem_ctrl(exmem_ctrl), .exmem_valid(exmem_valid),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // Instruction memory: content is a fixed function of the address.
  assign instr_in = force_zero ? 32'd0 : (pc ^ K);

  // Reference model
  logic [31:0]       m_pc, m_ifi, m_pc4;
  logic [CTRL_W-1:0] m_idc, m_exc;
  logic              m_idv, m_exv;
  int                m_run;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 0; m_ifi <= 0; m_pc4 <= 0;
      m_idc <= 0; m_idv <= 0; m_exc <= 0; m_exv <= 0;
      m_run <= 0;
    end else begin
      m_exc <= flush_exmem ? '0 : m_idc;
      m_exv <= flush_exmem ? 1'b0 : m_idv;
      m_idc <= (ctrl_bubble || flush_idex) ? '0 : ctrl_id;
      m_idv <= (ctrl_bubble || flush_idex) ? 1'b0 : (m_ifi != 0);
      if (flush_ifid || branch_taken || jump_taken) begin
        m_ifi <= 0; m_pc4 <= 0;
      end else if (!ifid_hold) begin
        m_ifi <= force_zero ? 32'd0 : (m_pc ^ K);
        m_pc4 <= m_pc + 32'd4;
      end
      m_pc  <= branch_taken ? branch_target : jump_taken ? jump_target :
               pc_hold ? m_pc : m_pc + 32'd4;
      m_run <= (pc_hold && !branch_taken && !jump_taken) ? m_run + 1 : 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("pc", pc, m_pc);
      check("ifid_instr", ifid_instr, m_ifi);
      check("ifid_pc4", ifid_pc4, m_pc4);
      check("idex_ctrl", 32'(idex_ctrl), 32'(m_idc));
      check("idex_valid", 32'(idex_valid), 32'(m_idv));
      check("exmem_ctrl", 32'(exmem_ctrl), 32'(m_exc));
      check("exmem_valid", 32'(exmem_valid), 32'(m_exv));
      check("stall_timeout", 32'(stall_timeout), 32'(m_run >= STALL_LIMIT));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    ctrl_id = 16'($urandom);
  endtask

  task automatic clear_ctl();
    pc_hold = 0; ifid_hold = 0; ctrl_bubble = 0;
    flush_ifid = 0; flush_idex = 0; flush_exmem = 0;
    branch_taken = 0; jump_taken = 0; force_zero = 0;
  endtask

  initial begin
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_ifid_instr", ifid_instr, 32'h0);
    check("rst_idex_valid", 32'(idex_valid), 32'h0);
    check("rst_timeout", 32'(stall_timeout), 32'h0);
    rst = 0;
    cyc();
    check("run_pc4", pc, 32'h4);
    check("run_ifid_instr", ifid_instr, K);
    check("run_ifid_pc4", ifid_pc4, 32'h4);
    cyc();
    check("run_pc8", pc, 32'h8);
    check("run_idex_valid", 32'(idex_valid), 32'h1);
    // stall at pc=8
    pc_hold = 1; ifid_hold = 1; ctrl_bubble = 1;
    cyc();
    check("stall1_pc", pc, 32'h8);
    check("stall1_idex_valid", 32'(idex_valid), 32'h0);
    cyc();
    check("stall2_pc", pc, 32'h8);
    check("stall2_ifid_instr", ifid_instr, 32'h4 ^ K);
    check("stall2_idex_valid", 32'(idex_valid), 32'h0);
    clear_ctl();
    cyc();
    check("release_pc", pc, 32'hC);
    // branch with hold
    pc_hold = 1;
    cyc();
    branch_taken = 1; branch_target = 32'h40;
    cyc();
    check("br_pc", pc, 32'h40);
    check("br_ifid_instr", ifid_instr, 32'h0);
    clear_ctl();
    repeat (3) cyc();
    check("pre_flush_exmem_valid", 32'(exmem_valid), 32'h1);
    flush_exmem = 1;
    cyc();
    check("flush_exmem_valid", 32'(exmem_valid), 32'h0);
    clear_ctl();
    flush_ifid = 1; ifid_hold = 1;
    cyc();
    check("flush_beats_hold", ifid_instr, 32'h0);
    clear_ctl();
    flush_idex = 1;
    cyc();
    clear_ctl();
    force_zero = 1;
    cyc();
    clear_ctl();
    repeat (2) cyc();
    // jump, and branch priority over jump
    jump_taken = 1; jump_target = 32'h100;
    cyc();
    check("jump_pc", pc, 32'h100);
    branch_taken = 1; branch_target = 32'h200; jump_target = 32'h300;
    cyc();
    check("br_over_jump_pc", pc, 32'h200);
    clear_ctl();
    branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    cyc();
    clear_ctl();
    cyc();
    check("wrap_pc", pc, 32'h0);
    repeat (2) cyc();
    // watchdog
    pc_hold = 1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 14) check("wd_14", 32'(stall_timeout), 32'h0);
      if (k == 15) check("wd_15", 32'(stall_timeout), 32'h1);
      if (k == 20) check("wd_20", 32'(stall_timeout), 32'h1);
    end
    clear_ctl();
    cyc();
    check("wd_release", 32'(stall_timeout), 32'h0);
    // redirect clears the counter
    pc_hold = 1;
    repeat (14) cyc();
    branch_taken = 1; branch_target = 32'h80;
    cyc();
    branch_taken = 0;
    cyc();
    check("wd_after_redirect", 32'(stall_timeout), 32'h0);
    // reset mid-stall
    repeat (16) cyc();
    rst = 1;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_ifid_pc4", ifid_pc4, 32'h0);
    check("midrst_exmem_valid", 32'(exmem_valid), 32'h0);
    check("midrst_timeout", 32'(stall_timeout), 32'h0);
    clear_ctl();
    cyc();
    rst = 0;
    repeat (4) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
